// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // One displayed frame: decimal points above the four BCD nibbles.
  typedef struct packed {
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0][3:0] dig;
  } frame_t;
endpackage

// File: rtl/seg7_scan_display_if.sv
// Data-in / pins-out bundle between the counter datapath and the display driver.
interface seg7_scan_display_if;
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic                    upd;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (output digits_in, dp_in, blank_lz, upd,
                  input  seg, dp, an, frame_start);
  modport slave  (input  digits_in, dp_in, blank_lz, upd,
                  output seg, dp, an, frame_start);
endinterface

// File: rtl/bcd_to_seg7.sv
// Nibble to active-high 7-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pat
);
  always_comb begin
    pat = SEG_DASH;
    case (bcd)
      4'd0: pat = SEG_0;
      4'd1: pat = SEG_1;
      4'd2: pat = SEG_2;
      4'd3: pat = SEG_3;
      4'd4: pat = SEG_4;
      4'd5: pat = SEG_5;
      4'd6: pat = SEG_6;
      4'd7: pat = SEG_7;
      4'd8: pat = SEG_8;
      4'd9: pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_display.sv
// Tear-free 4-digit multiplexed 7-segment driver: pending data is committed
// to the displayed frame only when the scan wraps back to digit 0.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 24000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 res,
  seg7_scan_display_if.slave   bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0] con_t;
  logic [IW-1:0] idx;
  frame_t        disp, pend, in_frame;
  logic          pend_valid;
  logic          tick, wrap;

  logic [NUM_DIGITS-1:0][6:0] dec, pat;
  logic [NUM_DIGITS-1:1]      lz;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  fs_q;

  assign in_frame = {bus.dp_in, bus.digits_in};
  assign tick     = (con_t == CW'(SCAN_DIV - 1));
  assign wrap     = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (res) begin
      con_t      <= '0;
      idx        <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      con_t <= tick ? '0 : con_t + 1'b1;
      if (tick) idx <= idx + 1'b1;
      fs_q <= wrap;
      // An update landing on the wrap edge bypasses the pending register.
      if (wrap) begin
        if (bus.upd)         disp <= in_frame;
        else if (pend_valid) disp <= pend;
        pend_valid <= 1'b0;
      end else if (bus.upd) begin
        pend       <= in_frame;
        pend_valid <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_to_seg7 u_dec (.bcd(disp.dig[i]), .pat(dec[i]));
  end

  // lz[i]: digit i and every more-significant digit are zero.
  always_comb begin
    lz  = '0;
    pat = dec;
    lz[NUM_DIGITS-1] = (disp.dig[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 1; i--)
      lz[i] = (disp.dig[i] == 4'd0) && lz[i+1];
    for (int i = 1; i < NUM_DIGITS; i++)
      if (bus.blank_lz && lz[i]) pat[i] = SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      seg_q <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
      dp_q  <= SEG_ACTIVE_LOW;
      an_q  <= AN_ACTIVE_LOW ? '1 : '0;
    end else begin
      seg_q <= SEG_ACTIVE_LOW ? ~pat[idx] : pat[idx];
      dp_q  <= SEG_ACTIVE_LOW ? ~disp.dp[idx] : disp.dp[idx];
      an_q  <= AN_ACTIVE_LOW ? ~(NUM_DIGITS'(1) << idx) : (NUM_DIGITS'(1) << idx);
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=4 and active-low pins.
module tb_seg7_scan_display;
  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [6:0] seg_obs [4];
  logic       dp_obs  [4];
  logic [3:0] an_obs  [4];

  seg7_scan_display_if bus ();

  seg7_scan_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .res(res), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.frame_start === 1'b1) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_frame: frame_start not seen within 40 cycles, got %b required 1", bus.frame_start);
  endtask

  // Called on the cycle frame_start is seen; records digit 0..3 as scanned.
  task automatic cap_frame();
    for (int k = 0; k < 4; k++) begin
      step(k == 0 ? 1 : 4);
      seg_obs[k] = bus.seg;
      dp_obs[k]  = bus.dp;
      an_obs[k]  = bus.an;
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    bus.digits_in = d;
    bus.dp_in     = p;
    bus.upd       = 1'b1;
    step();
    bus.upd       = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    step(2);
    res = 1'b0;
    step(6);
    res = 1'b1;
    step();
    n_cmp++;
    if ({bus.seg, bus.dp, bus.an, bus.frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got seg=%h dp=%b an=%h fs=%b required seg=7f dp=1 an=f fs=0",
               bus.seg, bus.dp, bus.an, bus.frame_start);
    end
    step(2);
    res = 1'b0;
    n_cmp++;
    if (bus.an !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_an_hold: got %h required f", bus.an);
    end
    step();
    n_cmp++;
    if (bus.an !== 4'hE || bus.seg !== 7'h40) begin
      n_fail++;
      $display("FAIL reset_first_digit: got an=%h seg=%h required an=e seg=40", bus.an, bus.seg);
    end
    step(3);
    n_cmp++;
    if (bus.an !== 4'hE) begin
      n_fail++;
      $display("FAIL reset_pre_tick: got an=%h required e", bus.an);
    end
    step();
    n_cmp++;
    if (bus.an !== 4'hD) begin
      n_fail++;
      $display("FAIL reset_first_tick: got an=%h required d", bus.an);
    end
    step(4);
    n_cmp++;
    if (bus.an !== 4'hB) begin
      n_fail++;
      $display("FAIL reset_idx2: got an=%h required b", bus.an);
    end
    step(4);
    n_cmp++;
    if (bus.an !== 4'h7) begin
      n_fail++;
      $display("FAIL reset_idx3: got an=%h required 7", bus.an);
    end
    step(2);
    n_cmp++;
    if (bus.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fs_early: got %b required 0", bus.frame_start);
    end
    step();
    n_cmp++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fs_wrap: got %b required 1", bus.frame_start);
    end
  endtask

  task automatic test_basic();
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    bus.blank_lz = 1'b0;
    wait_frame();
    load(16'h1234, 4'h0);
    wait_frame();
    cap_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (seg_obs[k] !== exp_seg[k] || an_obs[k] !== exp_an[k] || dp_obs[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_digit%0d: got seg=%h an=%h dp=%b required seg=%h an=%h dp=1",
                 k, seg_obs[k], an_obs[k], dp_obs[k], exp_seg[k], exp_an[k]);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [6:0] exp_seg [4] = '{7'h40, 7'h78, 7'h7F, 7'h7F};
    bus.blank_lz = 1'b1;
    wait_frame();
    load(16'h0070, 4'h0);
    wait_frame();
    cap_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (seg_obs[k] !== exp_seg[k]) begin
        n_fail++;
        $display("FAIL lz_digit%0d: got seg=%h required %h", k, seg_obs[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_tearing();
    bus.blank_lz = 1'b0;
    wait_frame();
    load(16'h1111, 4'h0);
    wait_frame();
    step();
    n_cmp++;
    if (bus.seg !== 7'h79 || bus.an !== 4'hE) begin
      n_fail++;
      $display("FAIL tear_d0_old: got seg=%h an=%h required seg=79 an=e", bus.seg, bus.an);
    end
    step(3);
    load(16'h2222, 4'h0);
    n_cmp++;
    if (bus.seg !== 7'h79 || bus.an !== 4'hD) begin
      n_fail++;
      $display("FAIL tear_d1_old: got seg=%h an=%h required seg=79 an=d", bus.seg, bus.an);
    end
    step(4);
    n_cmp++;
    if (bus.seg !== 7'h79 || bus.an !== 4'hB) begin
      n_fail++;
      $display("FAIL tear_d2_old: got seg=%h an=%h required seg=79 an=b", bus.seg, bus.an);
    end
    step(4);
    n_cmp++;
    if (bus.seg !== 7'h79 || bus.an !== 4'h7) begin
      n_fail++;
      $display("FAIL tear_d3_old: got seg=%h an=%h required seg=79 an=7", bus.seg, bus.an);
    end
    step(3);
    n_cmp++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL tear_fs: got %b required 1", bus.frame_start);
    end
    cap_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (seg_obs[k] !== 7'h24) begin
        n_fail++;
        $display("FAIL tear_new_digit%0d: got seg=%h required 24", k, seg_obs[k]);
      end
    end
  endtask

  task automatic test_coincident();
    logic [6:0] exp_seg [4] = '{7'h3F, 7'h40, 7'h40, 7'h3F};
    bus.blank_lz = 1'b0;
    wait_frame();
    step(15);
    load(16'hA00B, 4'h0);
    n_cmp++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_fs: got %b required 1", bus.frame_start);
    end
    cap_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (seg_obs[k] !== exp_seg[k]) begin
        n_fail++;
        $display("FAIL coinc_digit%0d: got seg=%h required %h", k, seg_obs[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_dp();
    logic [6:0] exp_seg [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bus.blank_lz = 1'b1;
    wait_frame();
    load(16'h0000, 4'b0100);
    wait_frame();
    cap_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (seg_obs[k] !== exp_seg[k] || dp_obs[k] !== exp_dp[k]) begin
        n_fail++;
        $display("FAIL dp_digit%0d: got seg=%h dp=%b required seg=%h dp=%b",
                 k, seg_obs[k], dp_obs[k], exp_seg[k], exp_dp[k]);
      end
    end
  endtask

  task automatic test_reset_abort();
    bus.blank_lz = 1'b0;
    wait_frame();
    load(16'h8888, 4'hF);
    res = 1'b1;
    step(2);
    res = 1'b0;
    wait_frame();
    cap_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (seg_obs[k] !== 7'h40 || dp_obs[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_digit%0d: got seg=%h dp=%b required seg=40 dp=1", k, seg_obs[k], dp_obs[k]);
      end
    end
  endtask

  initial begin
    bus.digits_in = '0;
    bus.dp_in     = '0;
    bus.blank_lz  = 1'b0;
    bus.upd       = 1'b0;
    test_reset();
    test_basic();
    test_lz_blank();
    test_tearing();
    test_coincident();
    test_dp();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Consumer-side display driver for the BCD digit counters (0–9 per digit) in the timing blocks.
- Latches four BCD digits plus decimal points into a shadow register.
- Commits new values only at frame boundaries, so the display never tears.
- Time-multiplexes a 4-digit common-anode/cathode 7-segment display at a divided scan rate.
- Sits between the counter datapath and the board's segment/anode pins.

Parameters:
SCAN_DIV, 24000, clk cycles per digit slot (24 MHz / 24000 = 1 kHz digit rate); legal range 2..2^20.
SEG_ACTIVE_LOW, 1, 1 = seg and dp pins driven low to light.
AN_ACTIVE_LOW, 1, 1 = an pins driven low to select a digit.

Ports:
clk  in  1  system clock
res  in  1  synchronous reset, active-high
digits_in  in  16  four BCD nibbles; [3:0] = digit0 (rightmost), [15:12] = digit3
dp_in  in  4  decimal point per digit, bit i = digit i
blank_lz  in  1  enable leading-zero blanking
upd  in  1  one-cycle strobe: capture digits_in/dp_in into pending register
seg  out  7  segments, seg[6:0] = g,f,e,d,c,b,a
dp  out  1  decimal point of the currently selected digit
an  out  4  digit select, an[i] = digit i
frame_start  out  1  one-cycle pulse when pending data is committed / idx wraps to 0

Behaviour:
- Clock and reset: one clock (clk); res is synchronous, active-high; all state updates on posedge clk.
- Reset (res=1 at a clock edge) sets:
  - con_t=0, idx=0, disp/pend registers=0, pend_valid=0, frame_start=0.
  - seg, dp, an all inactive (with defaults: seg=7'h7F, dp=1, an=4'hF).
  - Reset mid-scan aborts the frame immediately; pending data is discarded.
- Scan divider:
  - con_t counts 0..SCAN_DIV-1 and wraps.
  - tick = (con_t==SCAN_DIV-1).
  - On tick, idx advances 0→1→2→3→0.
- Capture:
  - upd=1 loads pend <= {dp_in,digits_in} and sets pend_valid=1.
  - A later upd before commit overwrites pend (last write wins).
- Commit:
  - On a tick where idx==3 (wrap to 0), disp <= pend if pend_valid, then pend_valid clears. Otherwise disp holds.
  - frame_start=1 for that one cycle, whether or not pend_valid was set.
  - If upd coincides with the wrap tick, the incoming digits_in/dp_in commit directly to disp and pend_valid stays 0.
- Outputs:
  - seg, dp and an are registered and reflect idx one cycle after idx changes (one-cycle latency).
  - Exactly one an bit is active except during reset and the first cycle after reset.
- Decode:
  - 0–9 use standard patterns.
  - Nibble values 10–15 display a dash (g only).
  - With defaults, codes 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex); dash = 3F.
- Leading-zero blanking (blank_lz=1):
  - Digit i (i=3,2,1) is blanked (all segments off) if its value and every more-significant digit value are 0.
  - Digit0 is never blanked.
  - dp follows dp_in even on a blanked digit.
  - blank_lz is sampled live, not shadowed.
- Polarity: applied at the output register only; internal logic is active-high.

Decomposition:
- Shared package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high);
  - digit count constant NUM_DIGITS=4.
- One natural sub-module: bcd_to_seg7, a combinational nibble→7-bit active-high pattern decoder including the dash rule.
- Divider, idx counter, shadow/commit logic and output registers live in seg7_scan_display.

Test Plan (SCAN_DIV=4, default polarity):
1. Reset: hold res=1 for 3 cycles mid-scan → next edge seg=7F, dp=1, an=F, frame_start=0; after release, first tick at cycle 4 and idx sequence 0,1,2,3.
2. Basic display: upd with digits_in=16'h1234, dp_in=0, blank_lz=0 → after next wrap, frame_start pulses; an=E/D/B/7 present seg=19/30/24/79 (digits 4,3,2,1).
3. Leading-zero blanking: digits_in=16'h0070, blank_lz=1 → digit3 and digit2 seg=7F, digit1 seg=78, digit0 seg=40.
4. Tearing: upd 16'h1111 committed, then upd 16'h2222 at idx=1 → idx 2,3 still show 79; from next frame all show 24.
5. Coincident and invalid input: upd 16'hA00B exactly on the wrap tick → committed that same edge; digits 3 and 0 show 3F, digits 2 and 1 show 40; pend_valid stays 0.
6. Decimal point: dp_in=4'b0100, digits_in=0, blank_lz=1 → digit2 has seg=7F with dp=0, digit0 has seg=40 with dp=1.
